sram_march_bist: RTL and testbench



---
 rtl/sram_bist_pkg.sv | 44 ++++
 rtl/sram_march_bist_if.sv | 15 +
 rtl/sram_bist_addr_gen.sv | 36 +++
 rtl/sram_march_bist.sv | 201 ++++++++++++++++++++
 tb/tb_sram_march_bist.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the March C- SRAM BIST controller.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    ELEM_E0 = 3'd0,
    ELEM_E1 = 3'd1,
    ELEM_E2 = 3'd2,
    ELEM_E3 = 3'd3,
    ELEM_E4 = 3'd4,
    ELEM_E5 = 3'd5
  } march_elem_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Bit i describes element Ei.
  localparam logic [5:0] ELEM_DOWN   = 6'b111000;
  localparam logic [5:0] ELEM_HAS_RD = 6'b111110;
  localparam logic [5:0] ELEM_HAS_WR = 6'b011111;
  localparam logic [5:0] ELEM_RD_BG  = 6'b010100;
  localparam logic [5:0] ELEM_WR_BG  = 6'b001010;

  localparam logic [32:0] DEF_CMP_MASK = 33'h1_7FFF_FFFF;

  function automatic op_e first_op(input march_elem_e elem);
    op_e op;
    if (ELEM_HAS_RD[elem]) begin
      op = OP_RD;
    end else begin
      op = OP_WR;
    end
    return op;
  endfunction

endpackage

// File: rtl/sram_march_bist_if.sv
// Port-0 command/data bundle between the BIST controller and the SRAM macro.
interface sram_march_bist_if #(
  parameter int DATA_WIDTH = 33,
  parameter int ADDR_WIDTH = 6
);
  logic                  csb;
  logic                  web;
  logic                  spare_wen;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;

  modport master (output csb, web, spare_wen, addr, din, input dout);
  modport slave  (input csb, web, spare_wen, addr, din, output dout);
endinterface

// File: rtl/sram_bist_addr_gen.sv
// Up/down March address counter: load to the element's start address, step, flag last.
module sram_bist_addr_gen #(
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_WORDS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  load_down,
  input  logic                  step,
  input  logic                  step_down,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);

  logic [ADDR_WIDTH-1:0] addr_r;

  // Address register: load wins over step.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r <= ADDR_ZERO;
    end else if (load) begin
      addr_r <= load_down ? TOP_ADDR : ADDR_ZERO;
    end else if (step) begin
      addr_r <= step_down ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
    end else begin
      addr_r <= addr_r;
    end
  end

  assign last = step_down ? (addr_r == ADDR_ZERO) : (addr_r == TOP_ADDR);
  assign addr = addr_r;
endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller for a 32x33 SRAM macro, one operation per cycle.
// SRAM_BIST_CONTINUE_EN: run all operations and count mismatches instead of halting.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int                    DATA_WIDTH = 33,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    NUM_WORDS  = 32,
  parameter logic [DATA_WIDTH-1:0] CMP_MASK   = DEF_CMP_MASK
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_rdata,
`ifdef SRAM_BIST_CONTINUE_EN
  output logic [8:0]            err_count,
`endif
  sram_march_bist_if.master     sram
);
  bist_state_e state_r, state_nx_s;
  march_elem_e elem_r, elem_nx_s, rd_elem_r;
  op_e         op_r, op_nx_s;
  logic issue_s, load_s, load_down_s, step_s, last_s;
  logic accept_s, mismatch_s, halt_s, enter_done_s;
  logic [ADDR_WIDTH-1:0] addr_s, rd_addr_r, fail_addr_r;
  logic [DATA_WIDTH-1:0] din_r, fail_rdata_r;
  logic csb_r, web_r, spare_wen_r, rd_pend_r, rd_exp_r;
  logic busy_r, done_r, pass_r, fail_seen_r;
  logic [2:0] fail_elem_r;

  sram_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_WORDS(NUM_WORDS)) u_addr_gen (
    .clk(clk), .reset(reset), .load(load_s), .load_down(load_down_s),
    .step(step_s), .step_down(ELEM_DOWN[elem_r]), .addr(addr_s), .last(last_s)
  );

  // rd_* describe the read issued last cycle, whose data is on sram.dout now.
  assign accept_s   = (state_r == ST_IDLE) && start;
  assign mismatch_s = rd_pend_r && ((state_r == ST_RUN) || (state_r == ST_DRAIN)) &&
                      (((sram.dout ^ {DATA_WIDTH{rd_exp_r}}) & CMP_MASK) != {DATA_WIDTH{1'b0}});
`ifdef SRAM_BIST_CONTINUE_EN
  assign halt_s = 1'b0;
`else
  assign halt_s = mismatch_s;
`endif
  assign enter_done_s = (state_nx_s == ST_DONE) && (state_r != ST_DONE);

  // State and current-operation registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      elem_r  <= ELEM_E0;
      op_r    <= OP_WR;
    end else begin
      state_r <= state_nx_s;
      elem_r  <= elem_nx_s;
      op_r    <= op_nx_s;
    end
  end

  // Sequencing: pick the next operation, which is registered onto sram_* this edge.
  always_comb begin
    state_nx_s  = state_r;
    elem_nx_s   = elem_r;
    op_nx_s     = op_r;
    issue_s     = 1'b0;
    load_s      = 1'b0;
    load_down_s = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s  = ST_RUN;
          elem_nx_s   = ELEM_E0;
          op_nx_s     = first_op(ELEM_E0);
          issue_s     = 1'b1;
          load_s      = 1'b1;
          load_down_s = ELEM_DOWN[ELEM_E0];
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt_s) begin
          state_nx_s = ST_DONE;
        end else if ((op_r == OP_RD) && ELEM_HAS_WR[elem_r]) begin
          op_nx_s = OP_WR;
          issue_s = 1'b1;
        end else if (!last_s) begin
          op_nx_s = first_op(elem_r);
          step_s  = 1'b1;
          issue_s = 1'b1;
        end else if (elem_r == ELEM_E5) begin
          state_nx_s = ST_DRAIN;
        end else begin
          elem_nx_s   = march_elem_e'(elem_r + 3'd1);
          op_nx_s     = first_op(elem_nx_s);
          load_s      = 1'b1;
          load_down_s = ELEM_DOWN[elem_nx_s];
          issue_s     = 1'b1;
        end
      end
      ST_DRAIN: state_nx_s = ST_DONE;
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Registered macro command; reads leave din untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      csb_r       <= 1'b1;
      web_r       <= 1'b1;
      spare_wen_r <= 1'b0;
      din_r       <= {DATA_WIDTH{1'b0}};
    end else if (issue_s && (op_nx_s == OP_WR)) begin
      csb_r       <= 1'b0;
      web_r       <= 1'b0;
      spare_wen_r <= 1'b1;
      din_r       <= {DATA_WIDTH{ELEM_WR_BG[elem_nx_s]}};
    end else begin
      csb_r       <= !issue_s;
      web_r       <= 1'b1;
      spare_wen_r <= 1'b0;
      din_r       <= din_r;
    end
  end

  // Read-compare pipeline stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_r <= 1'b0;
      rd_exp_r  <= 1'b0;
      rd_addr_r <= {ADDR_WIDTH{1'b0}};
      rd_elem_r <= ELEM_E0;
    end else begin
      rd_pend_r <= !csb_r && web_r;
      rd_exp_r  <= ELEM_RD_BG[elem_r];
      rd_addr_r <= addr_s;
      rd_elem_r <= elem_r;
    end
  end

  // Status and first-failure capture.
  always_ff @(posedge clk) begin
    if (reset || accept_s) begin
      busy_r       <= accept_s && !reset;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      fail_seen_r  <= 1'b0;
      fail_addr_r  <= {ADDR_WIDTH{1'b0}};
      fail_elem_r  <= 3'd0;
      fail_rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (mismatch_s && !fail_seen_r) begin
        fail_seen_r  <= 1'b1;
        fail_addr_r  <= rd_addr_r;
        fail_elem_r  <= rd_elem_r;
        fail_rdata_r <= sram.dout;
      end
      if (enter_done_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
        pass_r <= !(fail_seen_r || mismatch_s);
      end
    end
  end

`ifdef SRAM_BIST_CONTINUE_EN
  logic [8:0] err_count_r;

  // Saturating mismatch counter, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (reset || accept_s) begin
      err_count_r <= 9'd0;
    end else if (mismatch_s && (err_count_r != 9'h1FF)) begin
      err_count_r <= err_count_r + 9'd1;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign err_count = err_count_r;
`endif

  assign sram.csb       = csb_r;
  assign sram.web       = web_r;
  assign sram.spare_wen = spare_wen_r;
  assign sram.addr      = addr_s;
  assign sram.din       = din_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign fail_addr      = fail_addr_r;
  assign fail_elem      = fail_elem_r;
  assign fail_rdata     = fail_rdata_r;
endmodule

// File: tb/tb_sram_march_bist.sv
// Randomised self-checking bench for sram_march_bist with a faultable SRAM model.
module tb_sram_march_bist;
  localparam int NW   = 32;
  localparam int NOPS = 320;
  localparam logic [32:0] MASK = 33'h1_7FFF_FFFF;

  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, pass;
  logic [5:0]  fail_addr;
  logic [2:0]  fail_elem;
  logic [32:0] fail_rdata;
`ifdef SRAM_BIST_CONTINUE_EN
  logic [8:0]  err_count;
`endif

  sram_march_bist_if #(.DATA_WIDTH(33), .ADDR_WIDTH(6)) sram ();

  sram_march_bist #(.DATA_WIDTH(33), .ADDR_WIDTH(6), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_rdata(fail_rdata),
`ifdef SRAM_BIST_CONTINUE_EN
    .err_count(err_count),
`endif
    .sram(sram)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cur_c = 0;

  // Fault configuration
  logic f_b31 = 1'b0;
  logic f_sa_en = 1'b0;
  int   f_sa_addr = 0, f_sa_bit = 0;
  logic f_sa_val = 1'b0;
  logic f_cp_en = 1'b0;
  int   f_cp_aggr = 0, f_cp_victim = 0;

  typedef struct packed {
    logic       wr;
    logic       bg;
    logic [2:0] elem;
    logic [5:0] addr;
  } op_t;
  op_t ops [NOPS];

  function automatic logic [32:0] read_val(int a, logic [32:0] v);
    logic [32:0] r;
    r = v;
    if (f_sa_en && a == f_sa_addr) r[f_sa_bit] = f_sa_val;
    if (f_b31) r[31] = 1'b1;
    return r;
  endfunction

  // Behavioural SRAM macro: command sampled at the edge, read data valid through the next cycle.
  logic [32:0] mem [NW];
  always @(posedge clk) begin
    if (!sram.csb) begin
      if (!sram.web) begin
        mem[sram.addr[4:0]] <= sram.spare_wen ? sram.din : {mem[sram.addr[4:0]][32], sram.din[31:0]};
        if (f_cp_en && int'(sram.addr) == f_cp_aggr && sram.din == {33{1'b1}})
          mem[f_cp_victim] <= ~mem[f_cp_victim];
      end else begin
        sram.dout <= read_val(int'(sram.addr), mem[sram.addr[4:0]]);
      end
    end
  end

  // Expand the March C- table into the flat operation list.
  function automatic void build_ops();
    int dn[6], n[6], w0[6], b0[6], b1[6];
    int idx, a;
    dn = '{0, 0, 0, 1, 1, 1};
    n  = '{1, 2, 2, 2, 2, 1};
    w0 = '{1, 0, 0, 0, 0, 0};
    b0 = '{0, 0, 1, 0, 1, 0};
    b1 = '{0, 1, 0, 1, 0, 0};
    idx = 0;
    for (int e = 0; e < 6; e++) begin
      for (int j = 0; j < NW; j++) begin
        a = (dn[e] != 0) ? (NW - 1 - j) : j;
        ops[idx] = '{wr: (w0[e] != 0), bg: (b0[e] != 0), elem: 3'(e), addr: 6'(a)};
        idx++;
        if (n[e] == 2) begin
          ops[idx] = '{wr: 1'b1, bg: (b1[e] != 0), elem: 3'(e), addr: 6'(a)};
          idx++;
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cur_c, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);        chk("rst_fail_addr", fail_addr, 0);
    chk("rst_fail_elem", fail_elem, 0); chk("rst_fail_rdata", fail_rdata, 0);
    chk("rst_csb", sram.csb, 1);     chk("rst_web", sram.web, 1);
    chk("rst_spare_wen", sram.spare_wen, 0);
    chk("rst_addr", sram.addr, 0);   chk("rst_din", sram.din, 0);
`ifdef SRAM_BIST_CONTINUE_EN
    chk("rst_err_count", err_count, 0);
`endif
  endtask

  // Reference: play the whole operation list against an ideal-plus-fault memory.
  task automatic compute_expect(output int k, output int cnt, output logic [5:0] fa,
                                output logic [2:0] fe, output logic [32:0] frd);
    logic [32:0] rm [NW];
    logic [32:0] r;
    int a;
    k = -1; cnt = 0; fa = 6'd0; fe = 3'd0; frd = 33'd0;
    for (int i = 0; i < NW; i++) rm[i] = 33'd0;
    for (int i = 0; i < NOPS; i++) begin
      a = int'(ops[i].addr);
      if (ops[i].wr) begin
        rm[a] = {33{ops[i].bg}};
        if (f_cp_en && a == f_cp_aggr && ops[i].bg) rm[f_cp_victim] = ~rm[f_cp_victim];
      end else begin
        r = read_val(a, rm[a]);
        if (((r ^ {33{ops[i].bg}}) & MASK) != 33'd0) begin
          if (k < 0) begin k = i; fa = ops[i].addr; fe = ops[i].elem; frd = r; end
          cnt++;
        end
      end
    end
  endtask

  // One BIST run, checked every cycle; reset_c > 0 aborts with reset in that cycle.
  task automatic run_bist(input int again_c, input int reset_c,
                          output int low_cnt, output int done_c);
    int k, cnt, end_c, n_iss;
    logic [5:0] fa; logic [2:0] fe; logic [32:0] frd;
    op_t op;
    compute_expect(k, cnt, fa, fe, frd);
`ifdef SRAM_BIST_CONTINUE_EN
    n_iss = NOPS; end_c = NOPS + 2;
`else
    if (k < 0) begin n_iss = NOPS; end_c = NOPS + 2; end
    else begin n_iss = (k + 2 < NOPS) ? k + 2 : NOPS; end_c = k + 3; end
`endif
    low_cnt = 0; done_c = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= end_c + 1; c++) begin
      cur_c = c;
      chk("busy", busy, (c < end_c) ? 1 : 0);
      chk("done", done, (c >= end_c) ? 1 : 0);
      chk("csb", sram.csb, (c <= n_iss) ? 0 : 1);
      if (sram.csb == 1'b0) low_cnt++;
      if (done && done_c < 0) done_c = c;
      if (c <= n_iss) begin
        op = ops[c-1];
        chk("web", sram.web, !op.wr);
        chk("spare_wen", sram.spare_wen, op.wr);
        chk("addr", sram.addr, op.addr);
        if (op.wr) chk("din", sram.din, {33{op.bg}});
      end
      if (c >= end_c) begin
        chk("pass", pass, (k < 0) ? 1 : 0);
        chk("fail_addr", fail_addr, fa);
        chk("fail_elem", fail_elem, fe);
        chk("fail_rdata", fail_rdata, frd);
`ifdef SRAM_BIST_CONTINUE_EN
        chk("err_count", err_count, cnt);
`endif
      end
      if (c == reset_c) begin
        reset = 1'b1;
        @(negedge clk);
        cur_c = c + 1;
        check_reset_vals();
        reset = 1'b0;
        return;
      end
      start = (c == again_c);
      @(negedge clk);
    end
    start = 1'b0;
    chk("csb_low_count", low_cnt, n_iss);
  endtask

  task automatic clear_faults();
    f_b31 = 1'b0; f_sa_en = 1'b0; f_cp_en = 1'b0;
  endtask

  int low, dc, gap;

  initial begin
    build_ops();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;

    // Fault-free
    clear_faults();
    run_bist(-1, -1, low, dc);
    chk("pin_free_low", low, 320);
    chk("pin_free_done_cycle", dc, 322);
    chk("pin_free_pass", pass, 1);

    // Bit 31 stuck-at-1 is masked
    clear_faults(); f_b31 = 1'b1;
    run_bist(-1, -1, low, dc);
    chk("pin_b31_pass", pass, 1);

    // Address 5 bit 0 stuck-at-0
    clear_faults(); f_sa_en = 1'b1; f_sa_addr = 5; f_sa_bit = 0; f_sa_val = 1'b0;
    run_bist(-1, -1, low, dc);
    chk("pin_sa_pass", pass, 0);
    chk("pin_sa_addr", fail_addr, 5);
    chk("pin_sa_elem", fail_elem, 2);
    chk("pin_sa_rdata0", fail_rdata[0], 0);

    // Coupling: writing ones to address 10 inverts address 9
    clear_faults(); f_cp_en = 1'b1; f_cp_aggr = 10; f_cp_victim = 9;
    run_bist(-1, -1, low, dc);
    chk("pin_cp_addr", fail_addr, 9);

    // Reset somewhere inside E3, then a clean full run
    clear_faults();
    run_bist(-1, $urandom_range(224, 161), low, dc);
    run_bist(-1, -1, low, dc);
    chk("pin_after_rst_pass", pass, 1);

    // Extra start while busy is ignored
    run_bist($urandom_range(300, 2), -1, low, dc);
    chk("pin_again_low", low, 320);

    // Random faults with random idle gaps
    for (int t = 0; t < 6; t++) begin
      clear_faults();
      if ($urandom_range(1, 0) == 0) begin
        f_sa_en = 1'b1; f_sa_addr = $urandom_range(NW - 1, 0);
        f_sa_bit = $urandom_range(32, 0); f_sa_val = 1'($urandom);
      end else begin
        f_cp_en = 1'b1; f_cp_aggr = $urandom_range(NW - 1, 0);
        f_cp_victim = (f_cp_aggr + $urandom_range(NW - 1, 1)) % NW;
      end
      gap = $urandom_range(4, 0);
      repeat (gap) @(negedge clk);
      run_bist(-1, -1, low, dc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
